// File: rtl/iddr_gearbox.sv
// DDR input capture with half-beat slip alignment and a beat-packing gearbox.
// Rise/fall pairs are aligned each cycle, then BEATS qualified pairs form one word.
module iddr_gearbox #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BEATS      = 2,
    parameter bit          FALL_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           d,
    input  logic                       enable,
    input  logic                       slip,
    output logic [WIDTH-1:0]           q0,
    output logic [WIDTH-1:0]           q1,
    output logic [2*WIDTH*BEATS-1:0]   q,
    output logic                       q_valid,
    output logic                       phase
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned QW = PW * BEATS;
    localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [WIDTH-1:0] fall_neg_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_prev_q;
    logic [WIDTH-1:0] q0_q, q0_d;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic             phase_q, phase_d;
    logic             phase_dly_q;
    logic             qual_q, qual_d;
    logic             take_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [QW-1:0]    acc_q, acc_d;
    logic [QW-1:0]    word_d;
    logic [QW-1:0]    qw_q, qw_d;
    logic             qv_q, qv_d;

    // Falling-edge path is a bare capture register only.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fall_neg_q <= '0;
        end else begin
            fall_neg_q <= d;
        end
    end

    // The pairing phase lags the slip register by one cycle so a new
    // pairing starts with the pair of the cycle after the slip.
    always_comb begin
        q0_d    = phase_dly_q ? fall_prev_q : rise_q;
        q1_d    = phase_dly_q ? rise_q : fall_neg_q;
        phase_d = phase_q ^ slip;
        qual_d  = enable & ~slip;
    end

    always_comb begin
        word_d = acc_q;
        word_d[PW*int'(cnt_q) +: PW] = {q1_q, q0_q};
        acc_d  = acc_q;
        cnt_d  = '0;
        qw_d   = qw_q;
        qv_d   = 1'b0;
        if (take_q) begin
            acc_d = word_d;
            if (cnt_q == LAST) begin
                qw_d = word_d;
                qv_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q      <= '0;
            fall_prev_q <= '0;
            q0_q        <= '0;
            q1_q        <= '0;
            phase_q     <= FALL_FIRST;
            phase_dly_q <= FALL_FIRST;
            qual_q      <= 1'b0;
            take_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            qw_q        <= '0;
            qv_q        <= 1'b0;
        end else begin
            rise_q      <= d;
            fall_prev_q <= fall_neg_q;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            phase_q     <= phase_d;
            phase_dly_q <= phase_q;
            qual_q      <= qual_d;
            take_q      <= qual_q;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            qw_q        <= qw_d;
            qv_q        <= qv_d;
        end
    end

    assign q0      = q0_q;
    assign q1      = q1_q;
    assign q       = qw_q;
    assign q_valid = qv_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_iddr_gearbox.sv
// Scoreboard bench for iddr_gearbox (WIDTH=8, BEATS=2).
// Stimulus pushes expected words; a monitor pops them on each q_valid.
module tb_iddr_gearbox;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  d;
    logic        enable;
    logic        slip;
    logic [7:0]  q0;
    logic [7:0]  q1;
    logic [31:0] q;
    logic        q_valid;
    logic        phase;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    iddr_gearbox #(.WIDTH(8), .BEATS(2), .FALL_FIRST(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .enable  (enable),
        .slip    (slip),
        .q0      (q0),
        .q1      (q1),
        .q       (q),
        .q_valid (q_valid),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: r is sampled at the rising edge, f at the falling edge.
    task automatic cyc(input logic [7:0] r, input logic [7:0] f,
                       input logic en, input logic sl);
        @(negedge clk);
        #1;
        d      = r;
        enable = en;
        slip   = sl;
        @(posedge clk);
        #1;
        d      = f;
        enable = 1'b0;
        slip   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && q_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %h expected none", q);
            end else begin
                chk("word", q, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        d       = 8'h00;
        enable  = 1'b0;
        slip    = 1'b0;

        for (int i = 0; i < 4; i++) cyc(8'hA5 ^ 8'(i), 8'h5A, 1'b1, 1'b0);
        chk("rst_q0", 32'(q0), 32'h0);
        chk("rst_q1", 32'(q1), 32'h0);
        chk("rst_q", q, 32'h0);
        chk("rst_qv", 32'(q_valid), 32'h0);
        chk("rst_phase", 32'(phase), 32'h0);
        reset_n = 1'b1;
        idle(3);
        chk("rel_q", q, 32'h0);
        chk("rel_q0", 32'(q0), 32'h0);

        exp_q.push_back(32'h44332211);
        cyc(8'h11, 8'h22, 1'b1, 1'b0);
        cyc(8'h33, 8'h44, 1'b1, 1'b0);
        chk("raw_q0_a", 32'(q0), 32'h11);
        chk("raw_q1_a", 32'(q1), 32'h22);
        idle(1);
        chk("raw_q0_b", 32'(q0), 32'h33);
        chk("raw_q1_b", 32'(q1), 32'h44);
        idle(3);
        chk("hold_q", q, 32'h44332211);

        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("phase_slip1", 32'(phase), 32'h1);
        exp_q.push_back(32'h44332211);
        cyc(8'h00, 8'h11, 1'b0, 1'b0);
        cyc(8'h22, 8'h33, 1'b1, 1'b0);
        cyc(8'h44, 8'h00, 1'b1, 1'b0);
        idle(1);
        chk("raw_q0_ph1", 32'(q0), 32'h33);
        chk("raw_q1_ph1", 32'(q1), 32'h44);
        idle(3);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("phase_slip2", 32'(phase), 32'h0);
        idle(2);

        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        end
        for (int k = 0; k < 8; k++) cyc(8'(2*k), 8'(2*k+1), 1'b1, 1'b0);
        idle(4);

        exp_q.push_back(32'h04030201);
        cyc(8'hAA, 8'hBB, 1'b1, 1'b0);
        cyc(8'hCC, 8'hDD, 1'b0, 1'b0);
        cyc(8'h01, 8'h02, 1'b1, 1'b0);
        cyc(8'h03, 8'h04, 1'b1, 1'b0);
        idle(4);

        cyc(8'h55, 8'h66, 1'b1, 1'b0);
        cyc(8'h77, 8'h88, 1'b1, 1'b0);
        #1;
        reset_n = 1'b0;
        idle(2);
        chk("midrst_q", q, 32'h0);
        reset_n = 1'b1;
        idle(1);
        exp_q.push_back(32'hD4C3B2A1);
        cyc(8'hA1, 8'hB2, 1'b1, 1'b0);
        cyc(8'hC3, 8'hD4, 1'b1, 1'b0);
        idle(4);

        cyc(8'h10, 8'h20, 1'b1, 1'b0);
        cyc(8'h30, 8'h40, 1'b1, 1'b1);
        chk("phase_coll", 32'(phase), 32'h1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("phase_back", 32'(phase), 32'h0);
        exp_q.push_back(32'h8D7C6B5A);
        cyc(8'h5A, 8'h6B, 1'b1, 1'b0);
        cyc(8'h7C, 8'h8D, 1'b1, 1'b0);
        idle(5);

        chk("pending_words", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iddr_gearbox.md
Name: iddr_gearbox

Overview:
Parametrised DDR input capture block for the PSRAM/external-bus read path. Replaces the fixed 1-bit IDDR model: captures a WIDTH-bit DDR bus on both clock edges and aligns each rise/fall pair with a half-cycle slip control. A gearbox then packs BEATS consecutive pairs into one wide word with a single-cycle valid strobe. Sits between the pad-level data inputs and the PSRAM controller read FSM.

Parameters:
WIDTH, 8, data bus width in bits per DDR half-beat.
BEATS, 2, clock cycles (rise+fall pairs) packed per output word; must be >= 1.
FALL_FIRST, 0, power-on/reset value of the slip phase (0: rise-first pairing, 1: fall-first pairing).

Ports:
clk  input  1  single clock; rising and falling edges both sample d.
reset_n  input  1  asynchronous active-low reset.
d  input  WIDTH  DDR data from pads.
enable  input  1  qualifies d: high during the clock cycle whose rising edge samples the first half-beat to be packed.
slip  input  1  one-cycle pulse; toggles the pairing phase by one half-beat.
q0  output  WIDTH  aligned pair, first half-beat (raw, every cycle).
q1  output  WIDTH  aligned pair, second half-beat (raw, every cycle).
q  output  2*WIDTH*BEATS  packed word.
q_valid  output  1  one-cycle strobe: q holds a new word.
phase  output  1  current slip phase.

Behaviour:
- Notation: R(n) = d at rising edge n; F(n) = d at the falling edge following rising edge n.
- Capture: R(n) is registered at rising edge n; F(n) is registered at the falling edge and retimed at rising edge n+1. No logic on the falling-edge path other than the capture register.
- Alignment (registered at rising edge n+1): phase=0: q0=R(n), q1=F(n). phase=1: q0=F(n-1), q1=R(n). F(n-1) is held in one extra register.
- Raw latency: pair for cycle n is visible on q0/q1 after rising edge n+1, regardless of enable.
- enable is delayed internally by one stage so that enable sampled at edge n qualifies the pair for cycle n.
- Gearbox: a beat counter runs 0..BEATS-1. Each qualified pair is placed at bit offset 2*WIDTH*count: q0 in the lower WIDTH bits, q1 in the next WIDTH bits. The first pair lands in the LSBs.
- Word output: when the pair for count=BEATS-1 is accepted, q is loaded with the full word at edge n+2 (n = cycle of the last pair) and q_valid is high for exactly one cycle. q holds its value until the next word is loaded. The counter wraps to 0.
- Back-to-back words: continuous enable yields one q_valid every BEATS cycles with no gap cycles.
- enable low for a qualifying cycle: the counter returns to 0 and the partial word is discarded. q and q_valid are unaffected, except that a word already completed still strobes.
- slip: sampled at rising edge. The phase toggles, the counter resets to 0 and the partial word is discarded. The new pairing applies to pairs from the next cycle on. If slip and enable are both high in the same cycle, slip wins and that pair is discarded.
- Reset (async, reset_n=0): all capture, pair and word registers are 0; q0=q1=q=0; q_valid=0; counter=0; phase=FALL_FIRST. Reset asserted mid-word discards the partial word with no q_valid. The first qualified pair after release starts at count 0.
- BEATS=1: every qualified cycle produces a word; q is equivalent to {q1,q0} registered one more stage.

Test Plan:
- Reset: hold reset_n=0 while toggling d -> q0=q1=q=0, q_valid=0, phase=FALL_FIRST. Release -> all outputs stay 0 until data is enabled.
- Basic pack (WIDTH=8, BEATS=2, phase 0): drive d=11,22 (cycle 0) and 33,44 (cycle 1) with enable high for 2 cycles -> q=0x44332211, q_valid high for one cycle after edge 3. Raw q0/q1 show 11/22 then 33/44.
- Slip: pulse slip, then drive the same stream with the stream's first valid byte on the falling edge -> phase=1 and q=0x44332211. A second slip pulse -> phase=0.
- Continuous: enable high for 8 cycles of incrementing bytes 00..0F -> four q_valid strobes spaced 2 cycles apart: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
- Interruption: enable high for 1 cycle, low for 1, then high for 2 -> only the last 2 cycles form a word. No q_valid for the orphan pair.
- Reset mid-word and slip+enable collision -> no q_valid for the aborted word. The next word is packed from count 0 with correct byte order.
